// File: rtl/vx_cache_req_if.sv
// Multi-lane cache request/response bundle shared by cache masters and slaves.
// Lane i occupies bits [i*W +: W] of each packed vector.
interface vx_cache_req_if #(
  parameter int NUM_REQS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_SIZE  = DATA_WIDTH / 8
);

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0]            req_rw;
  logic [NUM_REQS*DATA_SIZE-1:0]  req_byteen;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQS-1:0]            req_ready;

  logic [NUM_REQS-1:0]            rsp_valid;
  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_tag;
  logic [NUM_REQS-1:0]            rsp_ready;

  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/vx_cache_req_responder.sv
// Slave end of the cache request interface backed by a local word-addressed
// SRAM. Round-robin lane arbitration, one request per cycle, single-entry
// response register with backpressure, read latency of one cycle.
// Optional macro VX_RSP_WRITE_ACK_EN: writes also return a response
// (tag echoed, data zero) through the same response slot.
module vx_cache_req_responder #(
  parameter int NUM_REQS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_SIZE  = DATA_WIDTH / 8
) (
  input logic            clk,
  input logic            reset,
  vx_cache_req_if.slave  bus
);

  localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      gidx;
  logic [PTR_W-1:0]      rsp_lane;
  logic [NUM_REQS-1:0]   grant;
  logic [NUM_REQS-1:0]   rsp_valid_q;
  logic                  found;
  logic                  can_accept;
  logic                  fire;
  logic                  drain;

  logic                  sel_rw;
  logic [DATA_SIZE-1:0]  sel_byteen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [IDX_W-1:0]      idx;
  logic                  unused_addr_hi;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;

  // Round-robin pick of the first valid lane starting at ptr, then mux its fields.
  always_comb begin
    int unsigned      c;
    logic [PTR_W-1:0] cand;
    c          = 0;
    cand       = '0;
    grant      = '0;
    gidx       = '0;
    found      = 1'b0;
    sel_rw     = 1'b0;
    sel_byteen = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_tag    = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      c    = (32'(ptr) + k) % NUM_REQS;
      cand = PTR_W'(c);
      if (!found && bus.req_valid[cand]) begin
        found       = 1'b1;
        gidx        = cand;
        grant[cand] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      if (gidx == PTR_W'(k)) begin
        sel_rw     = bus.req_rw[k];
        sel_byteen = bus.req_byteen[k*DATA_SIZE +: DATA_SIZE];
        sel_addr   = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_tag    = bus.req_tag[k*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign drain      = rsp_valid_q[rsp_lane] & bus.rsp_ready[rsp_lane];
  assign can_accept = ~(|rsp_valid_q) | drain;
  assign fire       = found & can_accept;
  assign idx        = sel_addr[IDX_W-1:0];

  // Upper address bits are intentionally dropped so addresses wrap.
  assign unused_addr_hi = ^sel_addr[ADDR_WIDTH-1:IDX_W];

  assign bus.req_ready = grant & {NUM_REQS{can_accept}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = {NUM_REQS{rsp_data_q}};
  assign bus.rsp_tag   = {NUM_REQS{rsp_tag_q}};

  // Byte-enabled SRAM write on a write fire; contents survive reset.
  always_ff @(posedge clk) begin
    if (fire && sel_rw) begin
      for (int unsigned b = 0; b < DATA_SIZE; b++) begin
        if (sel_byteen[b]) mem[idx][b*8 +: 8] <= sel_data[b*8 +: 8];
      end
    end
  end

  // Arbitration pointer and response slot: load on fire, clear on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      rsp_valid_q <= '0;
      rsp_lane    <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (fire) begin
        ptr <= (gidx == PTR_W'(NUM_REQS - 1)) ? '0 : gidx + 1'b1;
      end
      if (fire && !sel_rw) begin
        rsp_valid_q <= grant;
        rsp_lane    <= gidx;
        rsp_data_q  <= mem[idx];
        rsp_tag_q   <= sel_tag;
      end
`ifdef VX_RSP_WRITE_ACK_EN
      else if (fire && sel_rw) begin
        rsp_valid_q <= grant;
        rsp_lane    <= gidx;
        rsp_data_q  <= '0;
        rsp_tag_q   <= sel_tag;
      end
`endif
      else if (drain) begin
        rsp_valid_q <= '0;
      end
    end
  end

endmodule
